player_motion_ctrl: RTL

- Controller that sequences the player sprite datapath.
- Converts raw button inputs into the sprite's column position (btn_col), applying frame-synchronous motion with acceleration and edge limits.
- Arbitrates missile launch requests to the missile/projectile block through a valid/ready handshake with a cooldown.
- Sits between the board button inputs and the VGA sprite/missile modules.

---
 rtl/player_motion_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/player_motion_ctrl.sv
// Player sprite controller: debounced buttons drive frame-synchronous motion with acceleration
// and edge limits, plus a missile launch handshake with cooldown. Define PLAYER_WRAP_EN to wrap at edges.
module player_motion_ctrl #(
  parameter int INIT_COL        = 305,
  parameter int MIN_COL         = 0,
  parameter int MAX_COL         = 609,
  parameter int PLAYER_W        = 30,
  parameter int PLAYER_ROW      = 440,
  parameter int SLOW_STEP       = 2,
  parameter int FAST_STEP       = 4,
  parameter int ACCEL_FRAMES    = 8,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  output logic [11:0] btn_col,
  output logic        moving,
  output logic        missile_valid,
  input  logic        missile_ready,
  output logic [11:0] missile_col,
  output logic [11:0] missile_row
);

  localparam int DBW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
  localparam int HW  = (ACCEL_FRAMES > 0) ? $clog2(ACCEL_FRAMES + 2) : 1;
  localparam int CW  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [12:0] MIN13  = 13'(MIN_COL);
  localparam logic [12:0] MAX13  = 13'(MAX_COL);
  localparam logic [12:0] SLOW13 = 13'(SLOW_STEP);
  localparam logic [12:0] FAST13 = 13'(FAST_STEP);

  typedef enum logic [1:0] {HOLD, MOVE_L, MOVE_R} mstate_e;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_COOL} fstate_e;

  // Button vectors are ordered {fire, right, left}.
  logic [2:0]          sync1_q, sync2_q;
  logic [2:0]          deb_q, deb_d;
  logic [2:0][DBW-1:0] dcnt_q, dcnt_d;

  mstate_e     mstate_q, mnext;
  logic [HW-1:0] hold_q;
  logic [11:0] col_q, col_next;
  logic        moving_q;
  logic [12:0] step;

  fstate_e     fstate_q;
  logic [CW-1:0] cool_q;
  logic        fire_prev_q;
  logic        mvalid_q;
  logic [11:0] mcol_q, mrow_q;

  function automatic logic [11:0] edge_limit(input logic [12:0] col, input logic [12:0] stp,
                                             input logic left);
    logic [12:0] r;
    if (left) begin
      if (col < MIN13 + stp)
`ifdef PLAYER_WRAP_EN
        r = MAX13 - (MIN13 + stp - col - 13'd1);
`else
        r = MIN13;
`endif
      else
        r = col - stp;
    end else begin
      if (col + stp > MAX13)
`ifdef PLAYER_WRAP_EN
        r = MIN13 + (col + stp - MAX13 - 13'd1);
`else
        r = MAX13;
`endif
      else
        r = col + stp;
    end
    return r[11:0];
  endfunction

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    if (frame_tick) begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (dcnt_q[i] == DBW'(DEBOUNCE_FRAMES - 1)) begin
            deb_d[i]  = ~deb_q[i];
            dcnt_d[i] = '0;
          end else begin
            dcnt_d[i] = dcnt_q[i] + DBW'(1);
          end
        end else begin
          dcnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      sync1_q <= {btn_fire, btn_right, btn_left};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Motion decision uses the debounced state as it stood before this frame_tick edge.
  always_comb begin
    mnext = HOLD;
    if (deb_q[0] && !deb_q[1])
      mnext = MOVE_L;
    else if (deb_q[1] && !deb_q[0])
      mnext = MOVE_R;
    step     = (mnext == mstate_q && hold_q == HW'(ACCEL_FRAMES)) ? FAST13 : SLOW13;
    col_next = edge_limit({1'b0, col_q}, step, mnext == MOVE_L);
  end

  // hold_q counts frames moved in the current direction, the entry frame counting as the first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstate_q <= HOLD;
      hold_q   <= '0;
      col_q    <= 12'(INIT_COL);
      moving_q <= 1'b0;
    end else if (frame_tick) begin
      mstate_q <= mnext;
      moving_q <= (mnext != HOLD);
      if (mnext == HOLD) begin
        hold_q <= '0;
      end else begin
        col_q <= col_next;
        if (mnext != mstate_q)
          hold_q <= HW'(1);
        else if (hold_q != HW'(ACCEL_FRAMES))
          hold_q <= hold_q + HW'(1);
      end
    end
  end

  // Fire edges arriving outside F_IDLE are dropped; fire_prev_q still tracks every frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fstate_q    <= F_IDLE;
      cool_q      <= '0;
      fire_prev_q <= 1'b0;
      mvalid_q    <= 1'b0;
      mcol_q      <= '0;
      mrow_q      <= '0;
    end else begin
      if (frame_tick)
        fire_prev_q <= deb_q[2];
      case (fstate_q)
        F_IDLE: begin
          if (frame_tick && deb_q[2] && !fire_prev_q) begin
            fstate_q <= F_REQ;
            mvalid_q <= 1'b1;
            mcol_q   <= col_q + 12'(PLAYER_W / 2);
            mrow_q   <= 12'(PLAYER_ROW - 1);
          end
        end
        F_REQ: begin
          if (mvalid_q && missile_ready) begin
            mvalid_q <= 1'b0;
            cool_q   <= CW'(COOLDOWN_FRAMES);
            fstate_q <= (COOLDOWN_FRAMES == 0) ? F_IDLE : F_COOL;
          end
        end
        F_COOL: begin
          if (frame_tick) begin
            cool_q <= cool_q - CW'(1);
            if (cool_q == CW'(1))
              fstate_q <= F_IDLE;
          end
        end
        default: fstate_q <= F_IDLE;
      endcase
    end
  end

  assign btn_col       = col_q;
  assign moving        = moving_q;
  assign missile_valid = mvalid_q;
  assign missile_col   = mcol_q;
  assign missile_row   = mrow_q;

endmodule
